// File: rtl/shift_load_pkg.sv
// Shared types and helpers for the shift-register load sequencer:
// FSM state encoding, default sizing and effective-length clamping.
package shift_load_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 2;

  // A length of zero or anything beyond the register width means a full-width load.
  function automatic int eff_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/shift_load_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a pointer that
// moves past the last granted requester on each advance strobe.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  input  logic [NUM_REQ-1:0] last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (last_i[k]) ptr_d = PTR_W'((k + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shift_load_ctrl.sv
// Arbitrates requesters onto one bidirectional shift register and feeds the winner's
// word serially. Optional full-load readback check enabled by SHIFT_LOAD_CHECK_EN.
module shift_load_ctrl
  import shift_load_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int LEN_W   = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       dir,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  input  logic [NUM_REQ*LEN_W-1:0] len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         rsp_q,
  output logic                     busy,
  output logic                     sr_sl,
  output logic                     sr_sr,
  output logic                     sr_din,
  input  logic [WIDTH-1:0]         sr_q,
  output logic                     err
);

  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, arb_gnt;
  logic               dir_q, dir_d, sel_dir;
  logic [WIDTH-1:0]   data_q, data_d, hold_q, hold_d, sel_data;
  logic [LEN_W-1:0]   cnt_q, cnt_d, sel_len, eff_len_w;
  logic [POS_W-1:0]   pos_q, pos_d, first_pos;
  logic               sl_q, sl_d, srr_q, srr_d, din_q, din_d;
`ifdef SHIFT_LOAD_CHECK_EN
  logic               full_q, full_d, err_q, err_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset_n(reset_n),
    .req_i  (req),
    .adv_i  (state_q == DONE),
    .last_i (gnt_q),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    sel_dir  = 1'b0;
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_dir  = dir[i];
        sel_data = data[i*WIDTH +: WIDTH];
        sel_len  = len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign eff_len_w = LEN_W'(eff_len(int'(sel_len), WIDTH));
  // Right shifts start from the top bit of the effective slice, left shifts from bit 0.
  assign first_pos = POS_W'(eff_len_w - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    sl_d    = sl_q;
    srr_d   = srr_q;
    din_d   = din_q;
`ifdef SHIFT_LOAD_CHECK_EN
    full_d  = full_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SHIFT;
          gnt_d   = arb_gnt;
          dir_d   = sel_dir;
          data_d  = sel_data;
          cnt_d   = eff_len_w - LEN_W'(1);
          sl_d    = ~sel_dir;
          srr_d   = sel_dir;
          din_d   = sel_dir ? sel_data[first_pos] : sel_data[0];
          pos_d   = sel_dir ? first_pos - POS_W'(1) : POS_W'(1);
`ifdef SHIFT_LOAD_CHECK_EN
          full_d  = (eff_len_w == LEN_W'(WIDTH));
`endif
        end
      end
      SHIFT: begin
        // cnt_q holds the bits still to drive after the one on sr_din now.
        if (cnt_q == '0) begin
          state_d = DONE;
          sl_d    = 1'b0;
          srr_d   = 1'b0;
          din_d   = 1'b0;
        end else begin
          din_d = data_q[pos_q];
          pos_d = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = sr_q;
`ifdef SHIFT_LOAD_CHECK_EN
        if (full_q && sr_q != data_q) err_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      sl_q    <= 1'b0;
      srr_q   <= 1'b0;
      din_q   <= 1'b0;
`ifdef SHIFT_LOAD_CHECK_EN
      full_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      sl_q    <= sl_d;
      srr_q   <= srr_d;
      din_q   <= din_d;
`ifdef SHIFT_LOAD_CHECK_EN
      full_q  <= full_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign gnt    = gnt_q;
  assign done   = (state_q == DONE) ? gnt_q : '0;
  // The register has settled by the DONE cycle, so pass it through live and hold afterwards.
  assign rsp_q  = (state_q == DONE) ? sr_q : hold_q;
  assign sr_sl  = sl_q;
  assign sr_sr  = srr_q;
  assign sr_din = din_q;
`ifdef SHIFT_LOAD_CHECK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Bench for shift_load_ctrl: register model, transaction-level reference model
// compared every cycle, plus directed loads with literal expectations.
module tb_shift_load_ctrl;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int LW = 4;

`ifdef SHIFT_LOAD_CHECK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req, dir, gnt, done;
  logic [N*W-1:0]  data;
  logic [N*LW-1:0] len;
  logic [W-1:0]  rsp_q, sr_q;
  logic          busy, sr_sl, sr_sr, sr_din, err;
  logic [W-1:0]  sr_reg = 8'h00;
  logic          force_zero = 1'b0;

  int checks = 0;
  int errors = 0;

  shift_load_ctrl #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .dir(dir), .data(data), .len(len),
    .gnt(gnt), .done(done), .rsp_q(rsp_q), .busy(busy),
    .sr_sl(sr_sl), .sr_sr(sr_sr), .sr_din(sr_din), .sr_q(sr_q), .err(err)
  );

  always #5 clk = ~clk;

  // External shift register: sl moves bits toward the LSB with din entering at the MSB,
  // sr moves toward the MSB with din entering at the LSB.
  assign sr_q = force_zero ? 8'h00 : sr_reg;
  always @(posedge clk) begin
    if (sr_sl)      sr_reg <= {sr_din, sr_reg[7:1]};
    else if (sr_sr) sr_reg <= {sr_reg[6:0], sr_din};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each grant expands into a queue of per-cycle steps.
  typedef struct packed {logic sl; logic sr; logic din; logic dn;} step_t;
  step_t    m_q[$];
  step_t    m_cur;
  int       m_ptr = 0, m_win = 0, m_len = 8, m_idx = 0, m_l = 0;
  logic     m_found, m_d, m_err = 1'b0, m_busy;
  logic [W-1:0] m_shadow = 8'h00, m_hold = 8'h00, m_data = 8'h00, m_view;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_ptr  = 0;
      m_hold = 8'h00;
      m_err  = 1'b0;
    end else if (m_q.size() != 0) begin
      m_cur = m_q.pop_front();
      if (m_cur.dn) begin
        m_view = force_zero ? 8'h00 : m_shadow;
        m_hold = m_view;
        if (CHK_ON && m_len == W && m_view != m_data) m_err = 1'b1;
        m_ptr = (m_win + 1) % N;
      end else if (m_cur.sl) m_shadow = {m_cur.din, m_shadow[7:1]};
      else if (m_cur.sr)     m_shadow = {m_shadow[6:0], m_cur.din};
    end else if (req != '0) begin
      m_found = 1'b0;
      for (int k = 0; k < N; k++) begin
        m_idx = (m_ptr + k) % N;
        if (!m_found && req[m_idx]) begin m_win = m_idx; m_found = 1'b1; end
      end
      m_data = data[m_win*W +: W];
      m_d    = dir[m_win];
      m_l    = int'(len[m_win*LW +: LW]);
      m_len  = (m_l == 0 || m_l > W) ? W : m_l;
      for (int b = 0; b < m_len; b++)
        m_q.push_back(step_t'({~m_d, m_d, m_data[m_d ? m_len-1-b : b], 1'b0}));
      m_q.push_back(step_t'(4'b0001));
    end
  end

  always @(negedge clk) begin
    m_busy = (m_q.size() != 0);
    m_cur  = m_busy ? m_q[0] : step_t'(4'b0000);
    chk("busy", busy, m_busy);
    chk("gnt", gnt, m_busy ? (2'b01 << m_win) : 2'b00);
    chk("done", done, (m_busy && m_cur.dn) ? (2'b01 << m_win) : 2'b00);
    chk("sr_sl", sr_sl, m_cur.sl);
    chk("sr_sr", sr_sr, m_cur.sr);
    if (m_cur.sl || m_cur.sr) chk("sr_din", sr_din, m_cur.din);
    chk("rsp_q", rsp_q, (m_busy && m_cur.dn) ? (force_zero ? 8'h00 : m_shadow) : m_hold);
    chk("err", err, m_err);
  end

  task automatic load(input int i, input logic d, input logic [7:0] w, input logic [3:0] l,
                      output logic [7:0] seq, output int nsl, output int nsr,
                      output int dcyc, output logic [7:0] rsp);
    @(posedge clk); #2;
    dir[i] = d; data[i*W +: W] = w; len[i*LW +: LW] = l; req[i] = 1'b1;
    @(posedge clk); #2;
    req[i] = 1'b0;
    seq = 8'h00; nsl = 0; nsr = 0; dcyc = 0; rsp = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (sr_sl) nsl++;
      if (sr_sr) nsr++;
      if (sr_sl || sr_sr) seq = {seq[6:0], sr_din};
      if (done[i] && dcyc == 0) begin dcyc = c; rsp = rsp_q; end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(posedge clk); n++; end
    #1 chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq, rsp;
    int nsl, nsr, dcyc, ng;
    int g_who[4], g_cyc[4];
    logic [1:0] prev;
    req = '0; dir = '0; data = '0; len = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp", rsp_q, 8'h00);
    chk("rst_sr", {sr_sl, sr_sr, sr_din, err}, 4'b0000);
    @(posedge clk); #2 reset_n = 1'b1;

    load(0, 1'b0, 8'hA5, 4'd0, seq, nsl, nsr, dcyc, rsp);
    chk("t1_din_seq", seq, 8'hA5);
    chk("t1_nsl", nsl, 8);
    chk("t1_nsr", nsr, 0);
    chk("t1_done_cyc", dcyc, 9);
    chk("t1_rsp", rsp, 8'hA5);
    chk("t1_rsp_held", rsp_q, 8'hA5);

    load(1, 1'b1, 8'h3C, 4'd8, seq, nsl, nsr, dcyc, rsp);
    chk("t2_din_seq", seq, 8'h3C);
    chk("t2_nsr", nsr, 8);
    chk("t2_nsl", nsl, 0);
    chk("t2_done_cyc", dcyc, 9);
    chk("t2_rsp", rsp, 8'h3C);

    @(posedge clk); #2;
    data = {8'h34, 8'h12}; dir = 2'b10; len = {4'd8, 4'd8}; req = 2'b11;
    ng = 0; prev = 2'b00;
    for (int k = 0; k < 4; k++) begin g_who[k] = -1; g_cyc[k] = -100; end
    for (int c = 1; c <= 60 && ng < 4; c++) begin
      @(negedge clk);
      if (gnt != 2'b00 && prev == 2'b00) begin
        g_who[ng] = gnt[1] ? 1 : 0; g_cyc[ng] = c; ng++;
      end
      prev = gnt;
    end
    @(posedge clk); #2 req = 2'b00;
    wait_idle(20);
    chk("t3_ngrants", ng, 4);
    chk("t3_who0", g_who[0], 0);
    chk("t3_who1", g_who[1], 1);
    chk("t3_who2", g_who[2], 0);
    chk("t3_who3", g_who[3], 1);
    chk("t3_space01", g_cyc[1] - g_cyc[0], 10);
    chk("t3_space23", g_cyc[3] - g_cyc[2], 10);

    load(0, 1'b0, 8'h00, 4'd8, seq, nsl, nsr, dcyc, rsp);
    chk("t4_clear_rsp", rsp, 8'h00);
    load(0, 1'b0, 8'h05, 4'd3, seq, nsl, nsr, dcyc, rsp);
    chk("t4_nsl", nsl, 3);
    chk("t4_seq", seq, 8'h05);
    chk("t4_done_cyc", dcyc, 4);
    chk("t4_rsp", rsp, 8'hA0);
    chk("t4_err", err, 1'b0);

    @(posedge clk); #2;
    data = {8'h0F, 8'hF0}; dir = 2'b10; len = {4'd8, 4'd8}; req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t5_first_gnt", gnt, 2'b10);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 2'b00);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 2'b00);
    chk("t5_rst_sr", {sr_sl, sr_sr, sr_din, err}, 4'b0000);
    chk("t5_rst_rsp", rsp_q, 8'h00);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_regrant", gnt, 2'b01);
    @(posedge clk); #2 req = 2'b00;
    wait_idle(20);

    @(posedge clk); #2 force_zero = 1'b1;
    load(0, 1'b0, 8'hFF, 4'd8, seq, nsl, nsr, dcyc, rsp);
    chk("t6_rsp_forced", rsp, 8'h00);
    chk("t6_err", err, CHK_ON);
    force_zero = 1'b0;
    load(1, 1'b1, 8'h81, 4'd8, seq, nsl, nsr, dcyc, rsp);
    chk("t6_rsp_next", rsp, 8'h81);
    chk("t6_err_sticky", err, CHK_ON);
    @(posedge clk); #2 reset_n = 1'b0;
    #1 chk("t6_err_cleared", err, 1'b0);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
